// File: rtl/operand_bypass_scoreboard.sv
// Operand bypass network and per-register in-flight writer scoreboard for a
// multi-lane in-order issue stage, with a stall-cycle performance counter.
module operand_bypass_scoreboard #(
    parameter int ISSUE_W = 2,
    parameter int XLEN    = 32,
    parameter int NSRC    = 3,
    parameter int CNT_W   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [ISSUE_W-1:0]             id_valid,
    input  logic [ISSUE_W*5-1:0]           id_rs1,
    input  logic [ISSUE_W*5-1:0]           id_rs2,
    input  logic [ISSUE_W*5-1:0]           id_rd,
    input  logic [ISSUE_W-1:0]             id_we,
    input  logic [ISSUE_W*XLEN-1:0]        id_rs1_data,
    input  logic [ISSUE_W*XLEN-1:0]        id_rs2_data,
    input  logic [NSRC*ISSUE_W-1:0]        byp_vld,
    input  logic [NSRC*ISSUE_W-1:0]        byp_rdy,
    input  logic [NSRC*ISSUE_W*5-1:0]      byp_rd,
    input  logic [NSRC*ISSUE_W*XLEN-1:0]   byp_data,
    input  logic [ISSUE_W-1:0]             wb_vld,
    input  logic [ISSUE_W*5-1:0]           wb_rd,
    output logic [ISSUE_W-1:0]             issue_mask,
    output logic                           stall,
    output logic [ISSUE_W*XLEN-1:0]        rs1_out,
    output logic [ISSUE_W*XLEN-1:0]        rs2_out,
    output logic [31:0]                    stall_cnt
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;
    logic [31:0]      busy;

    // Returns {hazard, data}: first matching source wins (youngest stage,
    // then highest lane); with no match a busy register is a hazard.
    function automatic logic [XLEN:0] resolve(
        input logic [4:0]      idx,
        input logic [XLEN-1:0] rf_data,
        input logic            reg_busy
    );
        logic            found;
        logic [XLEN:0]   res;
        found = 1'b0;
        res   = {1'b0, rf_data};
        if (idx != 5'd0) begin
            for (int s = 0; s < NSRC; s++) begin
                for (int l = ISSUE_W - 1; l >= 0; l--) begin
                    int b;
                    b = s * ISSUE_W + l;
                    if (!found && byp_vld[b] && (byp_rd[b*5 +: 5] == idx)) begin
                        found = 1'b1;
                        res   = byp_rdy[b] ? {1'b0, byp_data[b*XLEN +: XLEN]}
                                           : {1'b1, rf_data};
                    end
                end
            end
            if (!found && reg_busy) begin
                res = {1'b1, rf_data};
            end
        end
        return res;
    endfunction

    // While reset is held the scoreboard reads as empty.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            busy[r] = rst_n && (cnt_q[r] != '0);
        end
    end

    // NOTE: every output and temporary gets a default before any branch so
    // no path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        logic          prev;
        logic          blk;
        logic [XLEN:0] r1;
        logic [XLEN:0] r2;
        logic [4:0]    rs1_k;
        logic [4:0]    rs2_k;
        issue_mask = '0;
        rs1_out    = '0;
        rs2_out    = '0;
        prev       = !flush;
        for (int k = 0; k < ISSUE_W; k++) begin
            rs1_k = id_rs1[k*5 +: 5];
            rs2_k = id_rs2[k*5 +: 5];
            r1 = resolve(rs1_k, id_rs1_data[k*XLEN +: XLEN], busy[rs1_k]);
            r2 = resolve(rs2_k, id_rs2_data[k*XLEN +: XLEN], busy[rs2_k]);
            rs1_out[k*XLEN +: XLEN] = r1[XLEN-1:0];
            rs2_out[k*XLEN +: XLEN] = r2[XLEN-1:0];
            blk = 1'b0;
            for (int i = 0; i < k; i++) begin
                if (id_valid[i] && id_we[i] && (id_rd[i*5 +: 5] != 5'd0) &&
                    ((id_rd[i*5 +: 5] == rs1_k) || (id_rd[i*5 +: 5] == rs2_k))) begin
                    blk = 1'b1;
                end
            end
            prev          = prev && id_valid[k] && !r1[XLEN] && !r2[XLEN] && !blk;
            issue_mask[k] = prev;
        end
    end

    assign stall = |(id_valid & ~issue_mask);

    // Net writers in minus retires out, clamped at both ends.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = '0;
        end
        for (int r = 1; r < 32; r++) begin
            int net;
            net = int'(cnt_q[r]);
            for (int k = 0; k < ISSUE_W; k++) begin
                if (issue_mask[k] && id_we[k] && (id_rd[k*5 +: 5] == 5'(r))) begin
                    net = net + 1;
                end
                if (wb_vld[k] && (wb_rd[k*5 +: 5] == 5'(r))) begin
                    net = net - 1;
                end
            end
            if (net < 0) begin
                net = 0;
            end else if (net > CNT_MAX) begin
                net = CNT_MAX;
            end
            cnt_d[r] = flush ? '0 : CNT_W'(net);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // NOTE: the counter array is reset element by element because a stale
    // nonzero count would stall issue forever; state uses <= so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_operand_bypass_scoreboard.sv
// Directed bench for operand_bypass_scoreboard: bypass priority, hazards,
// intra-bundle RAW, scoreboard counting/saturation, flush and reset.
module tb_operand_bypass_scoreboard;

    localparam int ISSUE_W = 2;
    localparam int XLEN    = 32;
    localparam int NSRC    = 3;
    localparam int CNT_W   = 3;

    logic                         clk;
    logic                         rst_n;
    logic                         flush;
    logic [ISSUE_W-1:0]           id_valid;
    logic [ISSUE_W*5-1:0]         id_rs1;
    logic [ISSUE_W*5-1:0]         id_rs2;
    logic [ISSUE_W*5-1:0]         id_rd;
    logic [ISSUE_W-1:0]           id_we;
    logic [ISSUE_W*XLEN-1:0]      id_rs1_data;
    logic [ISSUE_W*XLEN-1:0]      id_rs2_data;
    logic [NSRC*ISSUE_W-1:0]      byp_vld;
    logic [NSRC*ISSUE_W-1:0]      byp_rdy;
    logic [NSRC*ISSUE_W*5-1:0]    byp_rd;
    logic [NSRC*ISSUE_W*XLEN-1:0] byp_data;
    logic [ISSUE_W-1:0]           wb_vld;
    logic [ISSUE_W*5-1:0]         wb_rd;
    logic [ISSUE_W-1:0]           issue_mask;
    logic                         stall;
    logic [ISSUE_W*XLEN-1:0]      rs1_out;
    logic [ISSUE_W*XLEN-1:0]      rs2_out;
    logic [31:0]                  stall_cnt;

    int tests = 0;
    int fails = 0;

    operand_bypass_scoreboard #(
        .ISSUE_W(ISSUE_W), .XLEN(XLEN), .NSRC(NSRC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_we(id_we), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .byp_vld(byp_vld), .byp_rdy(byp_rdy), .byp_rd(byp_rd), .byp_data(byp_data),
        .wb_vld(wb_vld), .wb_rd(wb_rd),
        .issue_mask(issue_mask), .stall(stall),
        .rs1_out(rs1_out), .rs2_out(rs2_out), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        flush = 1'b0; id_valid = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = '0;
        id_rs1_data = '0; id_rs2_data = '0; byp_vld = '0; byp_rdy = '0; byp_rd = '0;
        byp_data = '0; wb_vld = '0; wb_rd = '0;
    endtask

    task automatic lane(input int k, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we);
        id_valid[k] = 1'b1;
        id_rs1[k*5 +: 5] = rs1;
        id_rs2[k*5 +: 5] = rs2;
        id_rd[k*5 +: 5]  = rd;
        id_we[k] = we;
    endtask

    task automatic src(input int s, input int l, input logic rdy, input logic [4:0] rd,
                       input logic [XLEN-1:0] d);
        int b;
        b = s * ISSUE_W + l;
        byp_vld[b] = 1'b1;
        byp_rdy[b] = rdy;
        byp_rd[b*5 +: 5] = rd;
        byp_data[b*XLEN +: XLEN] = d;
    endtask

    task automatic wb(input int k, input logic [4:0] rd);
        wb_vld[k] = 1'b1;
        wb_rd[k*5 +: 5] = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane 0 alone reads r with no bypass: issues only when cnt[r] is zero.
    task automatic probe(input string tag, input logic [4:0] r, input logic [1:0] exp_mask);
        clr();
        lane(0, r, 5'd0, 5'd0, 1'b0);
        #1;
        check(tag, 32'(issue_mask), 32'(exp_mask));
        clr();
    endtask

    initial begin
        // Reset: combinational path works with the scoreboard treated as empty.
        rst_n = 1'b0;
        clr();
        lane(0, 5'd3, 5'd0, 5'd0, 1'b0);
        id_rs1_data[31:0] = 32'h33;
        #1;
        check("rst_issue_comb", 32'(issue_mask), 32'h1);
        check("rst_rs1_rf", rs1_out[31:0], 32'h33);
        lane(0, 5'd0, 5'd0, 5'd3, 1'b1);
        lane(1, 5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        check("rst_stall", 32'(stall), 32'h1);
        tick();
        tick();
        check("rst_stall_cnt", stall_cnt, 32'h0);
        rst_n = 1'b1;
        clr();
        probe("rst_no_retained_write", 5'd3, 2'b01);

        // Bypass priority: highest lane inside youngest stage wins.
        src(0, 1, 1'b1, 5'd5, 32'hAA);
        src(0, 0, 1'b1, 5'd5, 32'hBB);
        src(1, 1, 1'b0, 5'd5, 32'hEE);
        lane(0, 5'd5, 5'd0, 5'd0, 1'b0);
        lane(1, 5'd0, 5'd0, 5'd0, 1'b0);
        id_rs1_data[31:0] = 32'h11;
        #1;
        check("byp_lane1_wins", rs1_out[31:0], 32'hAA);
        check("byp_issue_11", 32'(issue_mask), 32'h3);
        byp_vld[1:0] = 2'b00;
        #1;
        check("byp_stage1_notrdy_hazard", 32'(issue_mask), 32'h0);
        src(1, 1, 1'b1, 5'd5, 32'hCC);
        src(2, 1, 1'b1, 5'd5, 32'hDD);
        id_rs2[9:5] = 5'd5;
        #1;
        check("byp_stage1_before_2", rs1_out[31:0], 32'hCC);
        check("byp_lane1_rs2", rs2_out[63:32], 32'hCC);
        check("byp_issue_again", 32'(issue_mask), 32'h3);
        clr();

        // Load-use: not-ready source stalls until its data arrives.
        src(0, 0, 1'b0, 5'd7, 32'h0);
        lane(0, 5'd0, 5'd7, 5'd0, 1'b0);
        lane(1, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("load_mask", 32'(issue_mask), 32'h0);
        check("load_stall", 32'(stall), 32'h1);
        tick();
        tick();
        tick();
        check("load_stall_cnt", stall_cnt, 32'd3);
        byp_rdy[0] = 1'b1;
        byp_data[31:0] = 32'h77;
        #1;
        check("load_fwd_data", rs2_out[31:0], 32'h77);
        check("load_fwd_mask", 32'(issue_mask), 32'h3);
        tick();
        check("load_cnt_hold", stall_cnt, 32'd3);
        clr();

        // Intra-bundle RAW blocks lane 1; lane 0's write is scoreboarded.
        lane(0, 5'd0, 5'd0, 5'd3, 1'b1);
        lane(1, 5'd3, 5'd0, 5'd0, 1'b0);
        #1;
        check("raw_mask", 32'(issue_mask), 32'h1);
        check("raw_stall", 32'(stall), 32'h1);
        tick();
        check("raw_stall_cnt", stall_cnt, 32'd4);
        probe("cnt3_busy", 5'd3, 2'b00);
        wb(0, 5'd3);
        tick();
        clr();
        probe("cnt3_retired", 5'd3, 2'b01);
        wb(0, 5'd3);
        tick();
        clr();
        lane(0, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        clr();
        wb(1, 5'd3);
        tick();
        clr();
        probe("cnt3_floor_sat", 5'd3, 2'b01);

        // Set and clear of the same register in one cycle net out.
        lane(0, 5'd0, 5'd0, 5'd9, 1'b1);
        tick();
        clr();
        probe("cnt9_busy", 5'd9, 2'b00);
        src(2, 0, 1'b1, 5'd9, 32'h99);
        lane(0, 5'd9, 5'd0, 5'd0, 1'b0);
        #1;
        check("cnt9_match_overrides", rs1_out[31:0], 32'h99);
        clr();
        lane(0, 5'd0, 5'd0, 5'd9, 1'b1);
        wb(1, 5'd9);
        #1;
        check("cnt9_net_issue", 32'(issue_mask), 32'h1);
        tick();
        clr();
        probe("cnt9_still_one", 5'd9, 2'b00);
        wb(0, 5'd9);
        tick();
        clr();
        probe("cnt9_cleared", 5'd9, 2'b01);

        // Flush: squash bundle, zero scoreboard, ignore same-cycle traffic.
        lane(0, 5'd0, 5'd0, 5'd4, 1'b1);
        lane(1, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        clr();
        flush = 1'b1;
        lane(0, 5'd0, 5'd0, 5'd4, 1'b1);
        wb(0, 5'd4);
        #1;
        check("flush_mask", 32'(issue_mask), 32'h0);
        tick();
        check("flush_no_stall_cnt", stall_cnt, 32'd4);
        clr();
        wb(0, 5'd4);
        tick();
        clr();
        lane(0, 5'd0, 5'd0, 5'd4, 1'b1);
        tick();
        clr();
        probe("flush_cnt4_one", 5'd4, 2'b00);
        wb(0, 5'd4);
        tick();
        clr();
        probe("flush_cnt4_zero", 5'd4, 2'b01);

        // WAW: eight writers of r6 saturate the counter at 7.
        for (int c = 0; c < 4; c++) begin
            clr();
            lane(0, 5'd0, 5'd0, 5'd6, 1'b1);
            lane(1, 5'd0, 5'd0, 5'd6, 1'b1);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            clr();
            wb(0, 5'd6);
            wb(1, 5'd6);
            tick();
        end
        clr();
        probe("sat_cnt6_one_left", 5'd6, 2'b00);
        wb(0, 5'd6);
        tick();
        clr();
        probe("sat_cnt6_zero", 5'd6, 2'b01);
        src(0, 0, 1'b1, 5'd0, 32'h55);
        lane(0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check("x0_uses_rf", rs1_out[31:0], 32'h0);
        check("x0_no_stall", 32'(stall), 32'h0);
        clr();

        // Reset mid-stall discards pending scoreboard state.
        lane(0, 5'd0, 5'd0, 5'd12, 1'b1);
        tick();
        clr();
        probe("cnt12_busy", 5'd12, 2'b00);
        rst_n = 1'b0;
        lane(0, 5'd12, 5'd0, 5'd0, 1'b0);
        #1;
        check("rst_gates_cnt", 32'(issue_mask), 32'h1);
        check("pre_rst_stall_cnt", stall_cnt, 32'd4);
        tick();
        check("midrst_stall_cnt", stall_cnt, 32'h0);
        rst_n = 1'b1;
        clr();
        probe("cnt12_after_rst", 5'd12, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
